// File: rtl/memory_access_unit.sv
// MEM stage: word-addressed data RAM with byte/half/word access,
// branch/jump redirect resolution and the MEM/WB latch with forwarding.
module memory_access_unit #(
  parameter int NB_ADDR           = 5,
  parameter int NB_DATA           = 32,
  parameter int NB_LOAD_STORE_SEL = 2,
  parameter int NB_MEM_ADDR       = 10
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_flush,
  input  logic                         i_data_mem_wr_enb,
  input  logic                         i_data_mem_rd_enb,
  input  logic                         i_is_branch_instruction,
  input  logic                         i_is_jump_instruction,
  input  logic                         i_alu_zero,
  input  logic [NB_DATA-1:0]           i_alu_result,
  input  logic [NB_DATA-1:0]           i_branch_addr,
  input  logic [NB_DATA-1:0]           i_jump_addr,
  input  logic [NB_DATA-1:0]           i_rf_rt_data,
  input  logic [NB_LOAD_STORE_SEL-1:0] i_load_store_selector,
  input  logic                         i_load_unsigned,
  input  logic                         i_rf_wr_enb,
  input  logic                         i_rf_wr_data_src,
  input  logic [NB_ADDR-1:0]           i_rf_wr_addr,
  input  logic [NB_MEM_ADDR-1:0]       i_dbg_addr,
  output logic [NB_DATA-1:0]           o_dbg_data,
  output logic                         o_pc_redirect,
  output logic [NB_DATA-1:0]           o_pc_target,
  output logic                         o_misaligned,
  output logic [NB_DATA-1:0]           o_mem_data_ltchd,
  output logic [NB_DATA-1:0]           o_alu_result_ltchd,
  output logic                         o_rf_wr_enb_ltchd,
  output logic                         o_rf_wr_data_src_ltchd,
  output logic [NB_ADDR-1:0]           o_rf_wr_addr_ltchd,
  output logic [NB_DATA-1:0]           o_alu_operator_replacement
);

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;

  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];

  logic [NB_MEM_ADDR-1:0] word_idx;
  logic [1:0]             lane;
  logic [1:0]             sel;
  logic                   sel_ok;
  logic                   do_store;
  logic [3:0]             wr_be;
  logic [NB_DATA-1:0]     wr_word;
  logic [NB_DATA-1:0]     rd_word;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;
  logic [NB_DATA-1:0]     load_data;
  logic                   unused_alu_bits;

  assign word_idx = i_alu_result[NB_MEM_ADDR+1:2];
  assign lane     = i_alu_result[1:0];
  assign sel      = i_load_store_selector[1:0];
  assign sel_ok   = (sel != 2'b11);
  assign unused_alu_bits = ^i_alu_result[NB_DATA-1:NB_MEM_ADDR+2];

  assign o_pc_redirect = (i_is_branch_instruction & i_alu_zero)
                       | i_is_jump_instruction;
  assign o_pc_target   = i_is_jump_instruction ? i_jump_addr
                                               : i_branch_addr;

  always_comb begin
    o_misaligned = 1'b0;
    if (i_data_mem_rd_enb | i_data_mem_wr_enb) begin
      unique case (sel)
        SEL_HALF: o_misaligned = lane[0];
        SEL_WORD: o_misaligned = (lane != 2'b00);
        default:  o_misaligned = 1'b0;
      endcase
    end
  end

  assign do_store = i_enable & i_data_mem_wr_enb & ~i_flush
                  & ~i_reset & ~o_misaligned & sel_ok;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = '0;
    unique case (sel)
      SEL_BYTE: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{i_rf_rt_data[7:0]}};
      end
      SEL_HALF: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{i_rf_rt_data[15:0]}};
      end
      SEL_WORD: begin
        wr_be   = 4'b1111;
        wr_word = i_rf_rt_data;
      end
      default: ;
    endcase
  end

  // Lane-enabled write; RAM contents are deliberately not reset.
  always_ff @(posedge i_clock) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign rd_word    = mem[word_idx];
  assign o_dbg_data = mem[i_dbg_addr];
  assign byte_v     = rd_word[{lane, 3'b000} +: 8];
  assign half_v     = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (i_data_mem_rd_enb & ~o_misaligned) begin
      unique case (sel)
        SEL_BYTE: load_data = {{(NB_DATA-8){~i_load_unsigned & byte_v[7]}},
                               byte_v};
        SEL_HALF: load_data = {{(NB_DATA-16){~i_load_unsigned & half_v[15]}},
                               half_v};
        SEL_WORD: load_data = rd_word;
        default:  load_data = '0;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      o_mem_data_ltchd       <= '0;
      o_alu_result_ltchd     <= '0;
      o_rf_wr_enb_ltchd      <= 1'b0;
      o_rf_wr_data_src_ltchd <= 1'b0;
      o_rf_wr_addr_ltchd     <= '0;
    end else if (i_enable) begin
      o_mem_data_ltchd       <= load_data;
      o_alu_result_ltchd     <= i_alu_result;
      o_rf_wr_enb_ltchd      <= i_rf_wr_enb & ~o_misaligned;
      o_rf_wr_data_src_ltchd <= i_rf_wr_data_src;
      o_rf_wr_addr_ltchd     <= i_rf_wr_addr;
    end
  end

  assign o_alu_operator_replacement = o_rf_wr_data_src_ltchd ? o_mem_data_ltchd
                                                             : o_alu_result_ltchd;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: expected MEM/WB latch values
// are queued per edge and compared by an independent monitor.
module tb_memory_access_unit;

  typedef struct packed {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] repl;
    logic        wr;
    logic        src;
    logic [4:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, fl;
  logic        wr, rd, br, jp, zero, uns, rfwe, src;
  logic [31:0] alu, baddr, jaddr, rt;
  logic [1:0]  sel;
  logic [4:0]  rda;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_data, pc_target, mem_l, alu_l, repl;
  logic        redirect, misal, wr_l, src_l;
  logic [4:0]  addr_l;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .i_clock                    (clk),
    .i_reset                    (rst),
    .i_enable                   (en),
    .i_flush                    (fl),
    .i_data_mem_wr_enb          (wr),
    .i_data_mem_rd_enb          (rd),
    .i_is_branch_instruction    (br),
    .i_is_jump_instruction      (jp),
    .i_alu_zero                 (zero),
    .i_alu_result               (alu),
    .i_branch_addr              (baddr),
    .i_jump_addr                (jaddr),
    .i_rf_rt_data               (rt),
    .i_load_store_selector      (sel),
    .i_load_unsigned            (uns),
    .i_rf_wr_enb                (rfwe),
    .i_rf_wr_data_src           (src),
    .i_rf_wr_addr               (rda),
    .i_dbg_addr                 (dbg_addr),
    .o_dbg_data                 (dbg_data),
    .o_pc_redirect              (redirect),
    .o_pc_target                (pc_target),
    .o_misaligned               (misal),
    .o_mem_data_ltchd           (mem_l),
    .o_alu_result_ltchd         (alu_l),
    .o_rf_wr_enb_ltchd          (wr_l),
    .o_rf_wr_data_src_ltchd     (src_l),
    .o_rf_wr_addr_ltchd         (addr_l),
    .o_alu_operator_replacement (repl)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] m, input logic [31:0] a,
                              input logic w, input logic s,
                              input logic [4:0] d);
    exp_t e;
    e.mem  = m;
    e.alu  = a;
    e.wr   = w;
    e.src  = s;
    e.addr = d;
    e.repl = s ? m : a;
    return e;
  endfunction

  task automatic op(input logic w, input logic r, input logic [1:0] s,
                    input logic u, input logic [31:0] a,
                    input logic [31:0] d, input logic we,
                    input logic ds, input logic [4:0] ra);
    wr = w; rd = r; sel = s; uns = u; alu = a;
    rt = d; rfwe = we; src = ds; rda = ra;
  endtask

  task automatic step(input exp_t e);
    @(posedge clk);
    q.push_back(e);
    last = e;
    @(negedge clk);
  endtask

  task automatic dbg(input logic [9:0] idx, input logic [31:0] exp,
                     input string name);
    dbg_addr = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mem_data", mem_l, e.mem);
        check("alu_res", alu_l, e.alu);
        check("wr_enb", {31'd0, wr_l}, {31'd0, e.wr});
        check("wr_src", {31'd0, src_l}, {31'd0, e.src});
        check("wr_addr", {27'd0, addr_l}, {27'd0, e.addr});
        check("replace", repl, e.repl);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; fl = 1'b0;
    br = 1'b0; jp = 1'b0; zero = 1'b0;
    baddr = '0; jaddr = '0; dbg_addr = '0;
    op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0);
    @(negedge clk);
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));
    rst = 1'b0;

    op(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0);
    step(mk(32'h0, 32'h10, 0, 0, 5'd0));
    dbg(10'd4, 32'hDEADBEEF, "dbg_sw");
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd7);
    step(mk(32'hDEADBEEF, 32'h10, 1, 1, 5'd7));

    op(1, 0, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 5'd0);
    step(mk(32'h0, 32'h10, 0, 0, 5'd0));
    op(1, 0, 2'b00, 0, 32'h13, 32'h000000AB, 0, 0, 5'd0);
    step(mk(32'h0, 32'h13, 0, 0, 5'd0));
    dbg(10'd4, 32'hAB223344, "dbg_sb");
    op(0, 1, 2'b00, 0, 32'h13, 32'h0, 1, 1, 5'd2);
    step(mk(32'hFFFFFFAB, 32'h13, 1, 1, 5'd2));
    op(0, 1, 2'b00, 1, 32'h13, 32'h0, 1, 1, 5'd2);
    step(mk(32'h000000AB, 32'h13, 1, 1, 5'd2));
    op(0, 1, 2'b00, 0, 32'h12, 32'h0, 1, 1, 5'd2);
    step(mk(32'h00000022, 32'h12, 1, 1, 5'd2));
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd4);
    step(mk(32'hAB223344, 32'h10, 1, 1, 5'd4));

    op(1, 0, 2'b10, 0, 32'h04, 32'h0, 0, 0, 5'd0);
    step(mk(32'h0, 32'h04, 0, 0, 5'd0));
    op(1, 0, 2'b01, 0, 32'h06, 32'h00008001, 0, 0, 5'd0);
    #1 check("misal_sh6", {31'd0, misal}, 32'd0);
    step(mk(32'h0, 32'h06, 0, 0, 5'd0));
    dbg(10'd1, 32'h80010000, "dbg_sh");
    op(0, 1, 2'b01, 0, 32'h06, 32'h0, 1, 1, 5'd9);
    step(mk(32'hFFFF8001, 32'h06, 1, 1, 5'd9));
    op(0, 1, 2'b01, 1, 32'h06, 32'h0, 1, 1, 5'd9);
    step(mk(32'h00008001, 32'h06, 1, 1, 5'd9));

    op(1, 0, 2'b01, 0, 32'h05, 32'h00001234, 1, 0, 5'd4);
    #1 check("misal_sh5", {31'd0, misal}, 32'd1);
    step(mk(32'h0, 32'h05, 0, 0, 5'd4));
    dbg(10'd1, 32'h80010000, "dbg_misal");
    op(0, 1, 2'b10, 0, 32'h12, 32'h0, 1, 1, 5'd6);
    #1 check("misal_lw", {31'd0, misal}, 32'd1);
    step(mk(32'h0, 32'h12, 0, 1, 5'd6));
    op(0, 1, 2'b11, 0, 32'h10, 32'h0, 1, 1, 5'd6);
    #1 check("misal_rsv", {31'd0, misal}, 32'd0);
    step(mk(32'h0, 32'h10, 1, 1, 5'd6));

    br = 1'b1; zero = 1'b1; baddr = 32'h40; jaddr = 32'h80;
    #1 check("redir_tk", {31'd0, redirect}, 32'd1);
    check("target_br", pc_target, 32'h40);
    zero = 1'b0;
    #1 check("redir_nt", {31'd0, redirect}, 32'd0);
    jp = 1'b1;
    #1 check("redir_jp", {31'd0, redirect}, 32'd1);
    check("target_jp", pc_target, 32'h80);
    br = 1'b0; jp = 1'b0;

    op(1, 0, 2'b10, 0, 32'h20, 32'h12345678, 0, 0, 5'd0);
    step(mk(32'h0, 32'h20, 0, 0, 5'd0));
    op(1, 0, 2'b10, 0, 32'h20, 32'hCAFEF00D, 1, 0, 5'd3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(last);
      dbg(10'd8, 32'h12345678, "dbg_stall");
    end
    br = 1'b1; zero = 1'b1;
    #1 check("redir_stall", {31'd0, redirect}, 32'd1);
    br = 1'b0; zero = 1'b0;
    en = 1'b1;
    step(mk(32'h0, 32'h20, 1, 0, 5'd3));
    dbg(10'd8, 32'hCAFEF00D, "dbg_unstall");

    op(1, 0, 2'b10, 0, 32'h20, 32'h99999999, 1, 0, 5'd5);
    fl = 1'b1;
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));
    fl = 1'b0;
    dbg(10'd8, 32'hCAFEF00D, "dbg_flush");
    op(0, 1, 2'b10, 0, 32'h20, 32'h0, 1, 1, 5'd5);
    step(mk(32'hCAFEF00D, 32'h20, 1, 1, 5'd5));
    en = 1'b0; fl = 1'b1;
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));
    en = 1'b1; fl = 1'b0;

    step(mk(32'hCAFEF00D, 32'h20, 1, 1, 5'd5));
    en = 1'b0; rst = 1'b1;
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));
    rst = 1'b0; en = 1'b1;
    op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0);
    step(mk(32'h0, 32'h0, 0, 0, 5'd0));

    repeat (3) @(posedge clk);
    #2;
    check("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
